psum_pool_quant: RTL and testbench
==================================

Name: psum_pool_quant

Overview:
Downstream consumer of the partial-sum buffer's post-ReLU output stream (25-bit, one valid per pixel, raster order). Performs 2x2 stride-2 max pooling with a one-row line buffer. Requantizes each pooled value by a programmable right shift with unsigned saturation to 8 bits. Feeds the next layer's input buffer or the output writer.

Parameters:
DATA_W, 25, input data width (matches psum buffer data_width)
OUT_W, 8, output activation width
MAX_COLS, 60, maximum conv output row length (matches psum buffer depth)
COL_W, 6, width of column counter and cfg_row_len (must hold MAX_COLS)
SH_W, 5, width of cfg_shift

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_row_len  in  COL_W  conv output row length in pixels; static while a frame is in flight
cfg_shift  in  SH_W  requant right-shift amount, 0..24; static while a frame is in flight
frame_start  in  1  synchronous clear of counters; next accepted pixel is row 0 col 0
in_data  in  DATA_W  post-ReLU pixel, treated as unsigned
in_valid  in  1  in_data valid this cycle; gaps allowed, no backpressure
out_data  out  OUT_W  pooled, requantized activation
out_valid  out  1  out_data valid, single-cycle pulse per pooled pixel
out_last  out  1  high with out_valid on last pooled pixel of a pooled row

Behaviour:
- Reset (async, rst_n low): col_cnt=0, row_odd=0, pair register=0, out_data=0, out_valid=0, out_last=0. Line buffer contents are don't-care; no reset needed.
- Reset mid-frame: all progress discarded. The first pixel after release is row 0 col 0. No spurious out_valid.
- Counters: col_cnt increments on each accepted pixel (in_valid=1). At col_cnt==cfg_row_len-1 it wraps to 0 and row_odd toggles.
- frame_start: col_cnt<=0, row_odd<=0, pending pair discarded. If frame_start and in_valid are both high, frame_start wins and the beat is accepted as row 0 col 0.
- Horizontal stage: even col -> pixel stored in pair register. Odd col -> hmax = max(pair register, in_data).
- Even row: hmax is written to line_buf[col_cnt>>1]. No output.
- Odd row: pooled = max(hmax, line_buf[col_cnt>>1]). q = pooled >> cfg_shift, output = (q > 2^OUT_W-1) ? 2^OUT_W-1 : q[OUT_W-1:0].
- Latency: out_valid/out_data/out_last are registered. They appear exactly 1 cycle after the in_valid beat carrying the odd-column, odd-row pixel.
- out_valid is low on every other cycle. out_data holds its last value when out_valid is low.
- out_last is set when that beat's col_cnt == (cfg_row_len & ~1) - 1.
- Odd cfg_row_len: the final column of each row is counted but ignored (no line-buffer write, no output).
- cfg_row_len of 0 or 1: pixels are accepted and the counter wraps, but no outputs are produced.
- Odd number of rows in a frame: the trailing even row is buffered and never emitted. The next frame_start discards it.
- Stalls (in_valid low): all state holds. The pair register and line buffer persist across arbitrary gaps, including row boundaries.
- Ranges: line buffer is MAX_COLS/2 entries of DATA_W. Comparisons are unsigned. cfg_shift > 24 is illegal and its result is unspecified.

Test Plan:
- Basic pooling: row_len=4, shift=0; rows {1,5,2,3},{4,0,7,6} -> out 5 (out_last=0) then 7 (out_last=1), each 1 cycle after the odd-col beat.
- Requant/saturation: row_len=2, rows {1200,0},{0,0}. With shift=2 -> out 255 (saturated). With shift=4 -> out 75. With shift=0 and max value 255 -> out 255 (no saturation).
- Odd row length: row_len=5, rows {9,1,2,3,99},{0,0,0,0,0} -> exactly two outputs, 9 and 3. The value 99 is ignored. The next row starts at col 0.
- Stalls: repeat the basic test with in_valid low for 3 cycles between every pixel and across the row boundary -> identical outputs 5 and 7. out_valid is never high more than 1 cycle.
- frame_start mid-row: after 3 pixels of an odd row, assert frame_start together with in_valid (data 8). Then feed {8,2},{1,1} at row_len=2 -> single output 8. No output from the aborted row.
- Async reset mid-frame: drop rst_n between the two pooled rows -> outputs go to 0 immediately. After release, a fresh 2x2 frame {3,4},{5,6} with row_len=2 yields 6.

Source files
------------

// File: rtl/psum_pool_quant.sv
// rtl/psum_pool_quant.sv - 2x2 stride-2 max pool and shift/saturate requant of the post-ReLU psum stream
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   cfg_row_len   conv output row length in pixels (static during a frame)
//   cfg_shift     requant right shift, 0..24 (static during a frame)
//   frame_start   synchronous counter clear; a coincident beat becomes row 0 col 0
//   in_data       post-ReLU pixel (unsigned), qualified by in_valid, raster order
//   out_data      pooled, requantized activation (holds between pulses)
//   out_valid     single-cycle pulse per pooled pixel
//   out_last      marks the last pooled pixel of a pooled row

module psum_pool_quant #(
  parameter int DATA_W   = 25,
  parameter int OUT_W    = 8,
  parameter int MAX_COLS = 60,
  parameter int COL_W    = 6,
  parameter int SH_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [COL_W-1:0]  cfg_row_len,
  input  logic [SH_W-1:0]   cfg_shift,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int                LB_DEPTH   = MAX_COLS / 2;
  localparam logic [COL_W-1:0]  COL_ONE    = COL_W'(1);
  localparam logic [COL_W-1:0]  MAX_COLS_C = COL_W'(MAX_COLS);
  localparam logic [DATA_W-1:0] SAT_VAL    = DATA_W'((1 << OUT_W) - 1);

  logic [COL_W-1:0]  col_cnt;
  logic              row_odd;
  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] line_buf [LB_DEPTH];

  logic [COL_W-1:0]  col_eff;
  logic              row_eff;
  logic [COL_W-1:0]  even_len;
  logic              col_wrap;
  logic              pair_ok;
  logic [COL_W-2:0]  lb_idx;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] pooled;
  logic [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]  quant;

  // frame_start overrides the position so a coincident beat is processed as
  // row 0 col 0 through the same datapath as any other beat.
  always_comb begin
    col_eff  = frame_start ? '0 : col_cnt;
    row_eff  = frame_start ? 1'b0 : row_odd;
    even_len = cfg_row_len & ~COL_ONE;
    // cfg_row_len of 0 compares against all-ones, so the counter wraps naturally.
    col_wrap = (col_eff == cfg_row_len - COL_ONE);
    // Only complete column pairs pool; a trailing odd column is counted but dropped.
    pair_ok  = col_eff[0] && (col_eff < even_len) && (col_eff < MAX_COLS_C);
    lb_idx   = col_eff[COL_W-1:1];
    hmax     = (in_data > pair_reg) ? in_data : pair_reg;
    lb_rd    = line_buf[lb_idx];
    pooled   = (hmax > lb_rd) ? hmax : lb_rd;
    shifted  = pooled >> cfg_shift;
    quant    = (shifted > SAT_VAL) ? '1 : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      row_odd   <= 1'b0;
      pair_reg  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (frame_start) begin
        col_cnt  <= '0;
        row_odd  <= 1'b0;
        pair_reg <= '0;
      end
      if (in_valid) begin
        col_cnt <= col_wrap ? '0 : col_eff + COL_ONE;
        if (col_wrap) begin
          row_odd <= ~row_eff;
        end
        if (!col_eff[0]) begin
          pair_reg <= in_data;
        end
        if (pair_ok && row_eff) begin
          out_valid <= 1'b1;
          out_data  <= quant;
          out_last  <= (col_eff == even_len - COL_ONE);
        end
      end
    end
  end

  // Line buffer holds the even row's horizontal maxima; contents need no reset
  // because every odd-row read is preceded by an even-row write to that slot.
  always_ff @(posedge clk) begin
    if (in_valid && pair_ok && !row_eff) begin
      line_buf[lb_idx] <= hmax;
    end
  end

endmodule

// File: tb/tb_psum_pool_quant.sv
// tb/tb_psum_pool_quant.sv - randomized and directed bench for psum_pool_quant against a frame-level model

module tb_psum_pool_quant;

  localparam int DATA_W = 25;
  localparam int OUT_W  = 8;
  localparam int COL_W  = 6;
  localparam int SH_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [COL_W-1:0]  cfg_row_len = '0;
  logic [SH_W-1:0]   cfg_shift = '0;
  logic              frame_start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_last;

  psum_pool_quant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_row_len (cfg_row_len),
    .cfg_shift   (cfg_shift),
    .frame_start (frame_start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Frame-level model: pixels land in an image indexed by (row, col); each
  // pooled output is the max over its 2x2 window, shifted and clamped.
  int img [0:63][0:63];
  int m_row = 0;
  int m_col = 0;
  logic       exp_v = 1'b0;
  logic       exp_l = 1'b0;
  logic [7:0] exp_d = 8'd0;
  int r, c, len, elen, per, d, p, q;

  function automatic int max4(input int a, input int b, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_row <= 0;
      m_col <= 0;
      exp_v <= 1'b0;
      exp_l <= 1'b0;
      exp_d <= 8'd0;
    end else begin
      r    = frame_start ? 0 : m_row;
      c    = frame_start ? 0 : m_col;
      len  = int'(cfg_row_len);
      elen = len - (len % 2);
      per  = (len == 0) ? 64 : len;
      exp_v <= 1'b0;
      exp_l <= 1'b0;
      if (frame_start) begin
        m_row <= 0;
        m_col <= 0;
      end
      if (in_valid) begin
        d = int'(in_data);
        img[r % 64][c] <= d;
        if ((r % 2 == 1) && (c % 2 == 1) && (c < elen)) begin
          p = max4(img[(r - 1) % 64][c - 1], img[(r - 1) % 64][c], img[r % 64][c - 1], d);
          q = p >> cfg_shift;
          exp_v <= 1'b1;
          exp_d <= (q > 255) ? 8'hff : 8'(q);
          exp_l <= (c == elen - 1);
        end
        if (c + 1 >= per) begin
          m_col <= 0;
          m_row <= r + 1;
        end else begin
          m_col <= c + 1;
          m_row <= r;
        end
      end
    end
  end

  int got_q[$];
  int want_q[$];
  int stim_q[$];

  task automatic compare();
    checks++;
    if (out_valid !== exp_v) begin
      failures++;
      $display("FAIL out_valid t=%0t got %b want %b", $time, out_valid, exp_v);
    end
    checks++;
    if (out_data !== exp_d) begin
      failures++;
      $display("FAIL out_data t=%0t got %0d want %0d", $time, out_data, exp_d);
    end
    checks++;
    if (out_last !== (exp_v & exp_l)) begin
      failures++;
      $display("FAIL out_last t=%0t got %b want %b", $time, out_last, exp_v & exp_l);
    end
    if (out_valid === 1'b1) got_q.push_back(int'(out_data) + (out_last ? 256 : 0));
  endtask

  task automatic cyc(input bit fs, input bit v, input int dv);
    @(negedge clk);
    compare();
    frame_start = fs;
    in_valid    = v;
    in_data     = DATA_W'(dv);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 0);
  endtask

  task automatic feed(input bit fs_first, input int gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      cyc(fs_first && (i == 0), 1'b1, stim_q[i]);
      repeat (gap) cyc(1'b0, 1'b0, 0);
    end
  endtask

  task automatic setcfg(input int rl, input int sh);
    cfg_row_len = COL_W'(rl);
    cfg_shift   = SH_W'(sh);
  endtask

  task automatic check_got(input string name);
    checks++;
    if (got_q.size() != want_q.size()) begin
      failures++;
      $display("FAIL %s count got %0d want %0d", name, got_q.size(), want_q.size());
    end else begin
      for (int i = 0; i < want_q.size(); i++) begin
        checks++;
        if (got_q[i] != want_q[i]) begin
          failures++;
          $display("FAIL %s out[%0d] got %0d want %0d (last flag adds 256)", name, i, got_q[i], want_q[i]);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic literal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rows, n, rl, v;
    idle(3);
    literal("reset out_valid", int'(out_valid), 0);
    literal("reset out_data", int'(out_data), 0);
    literal("reset out_last", int'(out_last), 0);
    #2 rst_n = 1'b1;
    idle(2);
    got_q.delete();

    setcfg(4, 0);
    stim_q = '{1, 5, 2, 3, 4, 0, 7, 6};
    feed(1'b1, 0);
    idle(2);
    want_q = '{5, 7 + 256};
    check_got("basic");

    setcfg(2, 2);
    stim_q = '{1200, 0, 0, 0};
    feed(1'b1, 0);
    idle(2);
    want_q = '{255 + 256};
    check_got("sat_shift2");

    setcfg(2, 4);
    feed(1'b1, 0);
    idle(2);
    want_q = '{75 + 256};
    check_got("shift4");

    setcfg(2, 0);
    stim_q = '{255, 0, 0, 0};
    feed(1'b1, 0);
    idle(2);
    want_q = '{255 + 256};
    check_got("max_nosat");

    setcfg(5, 0);
    stim_q = '{9, 1, 2, 3, 99, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 0};
    feed(1'b1, 0);
    idle(2);
    want_q = '{9, 3 + 256, 2, 4 + 256};
    check_got("odd_len");

    setcfg(4, 0);
    stim_q = '{1, 5, 2, 3, 4, 0, 7, 6};
    feed(1'b1, 3);
    idle(2);
    want_q = '{5, 7 + 256};
    check_got("stall");

    setcfg(1, 0);
    stim_q = '{7, 8, 9, 10, 11, 12};
    feed(1'b1, 0);
    idle(1);
    setcfg(0, 0);
    stim_q = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    feed(1'b1, 0);
    idle(2);
    want_q.delete();
    check_got("short_rows");

    setcfg(4, 0);
    stim_q = '{1, 1, 1, 1, 2, 2, 2};
    feed(1'b1, 0);
    idle(1);
    got_q.delete();
    setcfg(2, 0);
    stim_q = '{8, 2, 1, 1};
    feed(1'b1, 0);
    idle(2);
    want_q = '{8 + 256};
    check_got("fs_mid_row");

    stim_q = '{3, 9};
    feed(1'b1, 0);
    idle(1);
    literal("hold before reset", int'(out_data), 8);
    #2 rst_n = 1'b0;
    #1;
    literal("async reset out_data", int'(out_data), 0);
    literal("async reset out_valid", int'(out_valid), 0);
    idle(2);
    #2 rst_n = 1'b1;
    stim_q = '{3, 4, 5, 6};
    feed(1'b0, 0);
    idle(2);
    want_q = '{6 + 256};
    check_got("after_reset");

    for (int f = 0; f < 40; f++) begin
      rl = (f == 0) ? 60 : int'($urandom_range(0, 12));
      setcfg(rl, int'($urandom_range(0, 24)));
      if (f % 4 == 1) cfg_shift = '0;
      rows = int'($urandom_range(1, 5));
      n = rows * ((rl == 0) ? 64 : rl);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       v = int'($urandom_range(0, 300));
          1:       v = int'($urandom_range(0, 16383));
          default: v = int'($urandom & 32'h01ff_ffff);
        endcase
        cyc((i == 0) || ($urandom_range(0, 60) == 0), 1'b1, v);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
